muscle_tdm_sched: RTL and testbench

MUSCLE_TDM_SCHED -- requirements
Module: muscle_tdm_sched

---
 rtl/muscle_tdm_sched.sv | 146 ++++++++++++++
 tb/tb_muscle_tdm_sched.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muscle_tdm_sched.sv
// ============================================================================
// Module   : muscle_tdm_sched
// Purpose  : Time-division scheduler sharing one muscle core across NCH channels.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muscle_tdm_sched #(
  parameter int NCH = 8,
  parameter int TMO = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  tick,
  input  logic [NCH*32-1:0]     spike_cnt_flat,
  output logic                  core_start,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] core_ch,
  output logic [31:0]           core_in,
  input  logic                  core_done,
  input  logic [31:0]           core_out,
  output logic [NCH*32-1:0]     force_flat,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  overrun,
  output logic                  timeout_err,
  output logic [7:0]            overrun_cnt
);

  localparam int c_cw = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int c_tw = $clog2(TMO + 1);
  localparam logic [c_cw-1:0] c_last = c_cw'(NCH - 1);
  localparam logic [c_tw-1:0] c_tmo  = c_tw'(TMO);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_cw-1:0]   r_ch;
  logic [c_tw-1:0]   r_wdog;
  logic [31:0]       r_shadow [NCH];
  logic [31:0]       r_result [NCH];
  logic [NCH*32-1:0] r_force;
  logic              r_overrun;
  logic              r_timeout;
  logic [7:0]        r_ovr_cnt;

  logic w_in_wait;
  logic w_advance;
  logic w_timeout;
  logic w_last;
  logic w_start_frame;
  logic w_drop_tick;

  assign w_in_wait     = (r_state == S_WAIT);
  assign w_advance     = w_in_wait && (core_done || (r_wdog == c_tmo));
  assign w_timeout     = w_in_wait && !core_done && (r_wdog == c_tmo);
  assign w_last        = (r_ch == c_last);
  assign w_start_frame = (r_state == S_IDLE) && tick && en;
  assign w_drop_tick   = (r_state != S_IDLE) && tick && en;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (tick && en) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (w_advance) w_state_nxt = w_last ? S_DONE : S_ISSUE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ch      <= '0;
      r_wdog    <= '0;
      r_force   <= '0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
      r_ovr_cnt <= 8'd0;
      for (int k = 0; k < NCH; k++) begin
        r_shadow[k] <= 32'd0;
        r_result[k] <= 32'd0;
      end
    end else begin
      r_state <= w_state_nxt;

      if (w_start_frame) begin
        for (int k = 0; k < NCH; k++) begin
          r_shadow[k] <= spike_cnt_flat[32*k +: 32];
        end
        r_ch <= '0;
      end

      if (r_state == S_ISSUE) begin
        r_wdog <= '0;
      end else if (w_in_wait && !w_advance) begin
        r_wdog <= r_wdog + c_tw'(1);
      end

      // On timeout the old result is kept; only a real answer overwrites it.
      if (w_advance) begin
        if (core_done) begin
          r_result[r_ch] <= core_out;
        end
        if (w_last) begin
          for (int k = 0; k < NCH; k++) begin
            r_force[32*k +: 32] <= (core_done && (k == NCH - 1)) ? core_out : r_result[k];
          end
        end else begin
          r_ch <= r_ch + c_cw'(1);
        end
      end

      if (w_timeout) begin
        r_timeout <= 1'b1;
      end

      if (w_drop_tick) begin
        r_overrun <= 1'b1;
        if (r_ovr_cnt != 8'hFF) begin
          r_ovr_cnt <= r_ovr_cnt + 8'd1;
        end
      end
    end
  end

  assign core_start  = (r_state == S_ISSUE);
  assign core_ch     = ((r_state == S_ISSUE) || w_in_wait) ? r_ch : '0;
  assign core_in     = ((r_state == S_ISSUE) || w_in_wait) ? r_shadow[r_ch] : 32'd0;
  assign force_flat  = r_force;
  assign frame_done  = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout;
  assign overrun_cnt = r_ovr_cnt;

endmodule

`default_nettype wire

// File: tb/tb_muscle_tdm_sched.sv
// ============================================================================
// Module   : tb_muscle_tdm_sched
// Purpose  : Directed self-checking bench for muscle_tdm_sched with a core model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_muscle_tdm_sched;

  localparam int NCH = 8;
  localparam int TMO = 64;

  logic              clk;
  logic              reset;
  logic              en;
  logic              tick;
  logic [NCH*32-1:0] spike_cnt_flat;
  logic              core_start;
  logic [2:0]        core_ch;
  logic [31:0]       core_in;
  logic              core_done;
  logic [31:0]       core_out;
  logic [NCH*32-1:0] force_flat;
  logic              frame_done;
  logic              busy;
  logic              overrun;
  logic              timeout_err;
  logic [7:0]        overrun_cnt;

  int checks = 0;
  int errors = 0;

  // core model state
  logic        pend = 1'b0;
  logic [2:0]  pend_ch;
  logic [31:0] pend_in;
  int          silent_ch = -1;
  logic        stray_req = 1'b0;

  logic [2:0]  st_ch [16];
  logic [31:0] st_in [16];
  int          hold_err;

  muscle_tdm_sched #(.NCH(NCH), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .en(en), .tick(tick),
    .spike_cnt_flat(spike_cnt_flat),
    .core_start(core_start), .core_ch(core_ch), .core_in(core_in),
    .core_done(core_done), .core_out(core_out),
    .force_flat(force_flat), .frame_done(frame_done), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err), .overrun_cnt(overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // IEEE-754 single of 2*c for c = 1..8; other counts map to a tagged pattern.
  function automatic logic [31:0] f2(input int c);
    case (c)
      1: return 32'h4000_0000;
      2: return 32'h4080_0000;
      3: return 32'h40C0_0000;
      4: return 32'h4100_0000;
      5: return 32'h4120_0000;
      6: return 32'h4140_0000;
      7: return 32'h4160_0000;
      8: return 32'h4180_0000;
      default: return {16'hBEEF, 16'(c)};
    endcase
  endfunction

  // Core answers during the cycle after a start, unless its channel is silenced.
  always begin
    @(posedge clk);
    #2;
    core_done = 1'b0;
    core_out  = 32'd0;
    if (pend) begin
      if (int'(pend_ch) != silent_ch) begin
        core_done = 1'b1;
        core_out  = f2(int'(pend_in));
      end
      pend = 1'b0;
    end
    if (core_start) begin
      pend    = 1'b1;
      pend_ch = core_ch;
      pend_in = core_in;
    end
    if (stray_req) begin
      core_done = 1'b1;
      core_out  = 32'h7F7F_7F7F;
      stray_req = 1'b0;
    end
  end

  task automatic set_counts(input int mode);
    for (int k = 0; k < NCH; k++) begin
      case (mode)
        0:       spike_cnt_flat[32*k +: 32] = 32'(k + 1);
        1:       spike_cnt_flat[32*k +: 32] = 32'(NCH - k);
        default: spike_cnt_flat[32*k +: 32] = 32'h55;
      endcase
    end
  endtask

  function automatic logic [NCH*32-1:0] exp_nominal();
    logic [NCH*32-1:0] v;
    for (int k = 0; k < NCH; k++) v[32*k +: 32] = f2(k + 1);
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tick  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Raise tick now (caller sits on a negedge) and follow the frame; lat counts cycles from the tick.
  task automatic run_frame(input int extra_off, input int chg_off, input int en_off,
                           input int budget, output int lat, output int n);
    logic       pstart;
    logic [2:0] pch;
    logic [31:0] pin;
    pstart   = 1'b0;
    pch      = 3'd0;
    pin      = 32'd0;
    hold_err = 0;
    lat      = -1;
    n        = 0;
    tick     = 1'b1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      tick = (i == extra_off);
      if (i == chg_off) set_counts(2);
      if (i == en_off) en = 1'b0;
      if (pstart && (core_ch !== pch || core_in !== pin)) hold_err++;
      pstart = core_start;
      pch    = core_ch;
      pin    = core_in;
      if (core_start && n < 16) begin
        st_ch[n] = core_ch;
        st_in[n] = core_in;
        n++;
      end
      if (frame_done) begin
        lat = i;
        break;
      end
    end
    tick = 1'b0;
    en   = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({core_start, busy, frame_done, overrun, timeout_err} !== 5'b0) begin
      $display("FAIL reset_flags: got %b, expected 00000",
               {core_start, busy, frame_done, overrun, timeout_err});
      errors++;
    end
    checks++;
    if (core_ch !== 3'd0 || core_in !== 32'd0 || overrun_cnt !== 8'd0) begin
      $display("FAIL reset_core_if: ch=%0d in=%0d ovr_cnt=%0d, expected all 0",
               core_ch, core_in, overrun_cnt);
      errors++;
    end
    checks++;
    if (force_flat !== '0) begin
      $display("FAIL reset_force: got %h, expected 0", force_flat);
      errors++;
    end
  endtask

  task automatic check_nominal_frame(input string tag, input int lat, input int n,
                                     input int exp_lat);
    logic ok;
    checks++;
    if (lat !== exp_lat) begin
      $display("FAIL %s_latency: got %0d, expected %0d", tag, lat, exp_lat);
      errors++;
    end
    ok = (n == NCH);
    for (int k = 0; k < NCH && k < n; k++) begin
      if (st_ch[k] !== 3'(k) || st_in[k] !== 32'(k + 1)) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      $display("FAIL %s_starts: got %0d starts (first ch=%0d in=%0d), expected 8 in order 0..7",
               tag, n, st_ch[0], st_in[0]);
      errors++;
    end
    checks++;
    if (force_flat !== exp_nominal()) begin
      $display("FAIL %s_force: got %h, expected %h", tag, force_flat, exp_nominal());
      errors++;
    end
  endtask

  task automatic test_nominal();
    int lat, n;
    do_reset();
    set_counts(0);
    en = 1'b1;
    run_frame(-1, -1, -1, 40, lat, n);
    check_nominal_frame("nominal", lat, n, 17);
    checks++;
    if (hold_err != 0) begin
      $display("FAIL nominal_hold: core_ch/core_in changed in WAIT %0d times, expected 0", hold_err);
      errors++;
    end
    checks++;
    if ({busy, overrun, timeout_err, core_ch} !== 6'b0 || core_in !== 32'd0) begin
      $display("FAIL nominal_idle: busy=%b ovr=%b tmo=%b ch=%0d in=%0d, expected all 0",
               busy, overrun, timeout_err, core_ch, core_in);
      errors++;
    end
  endtask

  task automatic test_overrun();
    int lat, n;
    run_frame(5, -1, -1, 40, lat, n);
    check_nominal_frame("overrun", lat, n, 17);
    checks++;
    if (overrun !== 1'b1 || overrun_cnt !== 8'd1) begin
      $display("FAIL overrun_single: overrun=%b cnt=%0d, expected 1 and 1", overrun, overrun_cnt);
      errors++;
    end
    tick = 1'b1;
    repeat (400) @(negedge clk);
    tick = 1'b0;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    checks++;
    if (overrun_cnt !== 8'd255 || busy !== 1'b0) begin
      $display("FAIL overrun_saturate: cnt=%0d busy=%b, expected 255 and 0", overrun_cnt, busy);
      errors++;
    end
  endtask

  task automatic test_timeout();
    int lat, n;
    logic [NCH*32-1:0] exp;
    do_reset();
    set_counts(0);
    run_frame(-1, -1, -1, 40, lat, n);
    set_counts(1);
    silent_ch = 3;
    run_frame(-1, -1, -1, 150, lat, n);
    silent_ch = -1;
    for (int k = 0; k < NCH; k++) exp[32*k +: 32] = (k == 3) ? f2(4) : f2(NCH - k);
    checks++;
    if (lat !== 17 + TMO || n !== NCH) begin
      $display("FAIL timeout_latency: lat=%0d starts=%0d, expected %0d and 8", lat, n, 17 + TMO);
      errors++;
    end
    checks++;
    if (timeout_err !== 1'b1) begin
      $display("FAIL timeout_flag: got %b, expected 1", timeout_err);
      errors++;
    end
    checks++;
    if (force_flat !== exp) begin
      $display("FAIL timeout_force: got %h, expected %h", force_flat, exp);
      errors++;
    end
  endtask

  task automatic test_reset_midframe();
    int lat, n;
    int bad;
    do_reset();
    set_counts(0);
    tick = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      tick = 1'b0;
      if (i == 6) begin
        reset     = 1'b1;
        stray_req = 1'b1;
      end
    end
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, core_start, frame_done, overrun, timeout_err, core_ch} !== 8'b0 ||
        core_in !== 32'd0 || force_flat !== '0 || overrun_cnt !== 8'd0) begin
      $display("FAIL midreset_state: busy=%b start=%b fd=%b ch=%0d in=%0d force=%h, expected all 0",
               busy, core_start, frame_done, core_ch, core_in, force_flat);
      errors++;
    end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || core_start || frame_done) bad++;
    end
    checks++;
    if (bad != 0 || force_flat !== '0) begin
      $display("FAIL midreset_quiet: %0d active cycles, force=%h, expected 0 and 0", bad, force_flat);
      errors++;
    end
    run_frame(-1, -1, -1, 40, lat, n);
    check_nominal_frame("postreset", lat, n, 17);
  endtask

  task automatic test_snapshot_enable();
    int lat, n;
    int bad;
    do_reset();
    set_counts(0);
    run_frame(-1, 3, 4, 40, lat, n);
    check_nominal_frame("snapshot", lat, n, 17);
    set_counts(0);
    en   = 1'b0;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    bad  = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || core_start) bad++;
    end
    checks++;
    if (bad != 0 || overrun !== 1'b0 || overrun_cnt !== 8'd0) begin
      $display("FAIL en_low_tick: %0d active cycles, overrun=%b cnt=%0d, expected 0,0,0",
               bad, overrun, overrun_cnt);
      errors++;
    end
    en        = 1'b1;
    stray_req = 1'b1;
    bad       = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy || core_start || frame_done) bad++;
    end
    checks++;
    if (bad != 0 || force_flat !== exp_nominal() || timeout_err !== 1'b0) begin
      $display("FAIL stray_done: %0d active cycles, force=%h, expected 0 and %h",
               bad, force_flat, exp_nominal());
      errors++;
    end
  endtask

  initial begin
    reset          = 1'b1;
    en             = 1'b1;
    tick           = 1'b0;
    spike_cnt_flat = '0;
    core_done      = 1'b0;
    core_out       = 32'd0;
    test_reset();
    test_nominal();
    test_overrun();
    test_timeout();
    test_reset_midframe();
    test_snapshot_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "time limit");
  end

endmodule

`default_nettype wire
